// File: rtl/instruction_fetch_unit.sv
// Two-step byte fetch of a little-endian 16-bit instruction at PC, bumping PC through the ARF after each byte.
// Optional macro FETCH_TIMEOUT_EN adds a memory wait timeout with a sticky Fault flag.
module instruction_fetch_unit #(
    parameter logic [7:0] TIMEOUT_CYCLES = 8'd15
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic [15:0] PcIn,
    input  logic [7:0]  MemData,
    input  logic        MemReady,
    output logic [15:0] MemAddr,
    output logic        MemRead,
    output logic [1:0]  ArfOutDSel,
    output logic [2:0]  ArfRegSel,
    output logic [1:0]  ArfFunSel,
    output logic [15:0] IR,
    output logic        IRValid,
    output logic        Busy,
    output logic        Fault
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH_LO,
        INC_LO,
        FETCH_HI,
        INC_HI,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  lo_byte_q, lo_byte_d;
    logic [15:0] ir_q, ir_d;

`ifdef FETCH_TIMEOUT_EN
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        fault_q, fault_d;
`else
    // A zero timeout has no meaning; the parameter only matters with the timeout build.
    if (TIMEOUT_CYCLES == 8'd0) begin : g_timeout_unused
    end
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= IDLE;
            lo_byte_q  <= 8'h00;
            ir_q       <= 16'h0000;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt_q <= 8'd0;
            fault_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            lo_byte_q  <= lo_byte_d;
            ir_q       <= ir_d;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt_q <= wait_cnt_d;
            fault_q    <= fault_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        lo_byte_d = lo_byte_q;
        ir_d      = ir_q;
`ifdef FETCH_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
        fault_d    = fault_q;
`endif
        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d = FETCH_LO;
`ifdef FETCH_TIMEOUT_EN
                    wait_cnt_d = 8'd0;
`endif
                end
            end
            FETCH_LO: begin
                if (MemReady) begin
                    lo_byte_d = MemData;
                    state_d   = INC_LO;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (wait_cnt_q == TIMEOUT_CYCLES - 8'd1) begin
                    fault_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
`endif
            end
            INC_LO: begin
                state_d = FETCH_HI;
`ifdef FETCH_TIMEOUT_EN
                wait_cnt_d = 8'd0;
`endif
            end
            FETCH_HI: begin
                if (MemReady) begin
                    ir_d    = {MemData, lo_byte_q};
                    state_d = INC_HI;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (wait_cnt_q == TIMEOUT_CYCLES - 8'd1) begin
                    fault_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
`endif
            end
            INC_HI: begin
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Moore outputs; PcIn is passed through as the address only while a byte is being requested.
    always_comb begin
        MemRead    = 1'b0;
        MemAddr    = 16'h0000;
        ArfOutDSel = 2'b00;
        ArfFunSel  = 2'b01;
        ArfRegSel  = 3'b000;
        IRValid    = 1'b0;
        Busy       = (state_q != IDLE);
        case (state_q)
            FETCH_LO, FETCH_HI: begin
                MemRead = 1'b1;
                MemAddr = PcIn;
            end
            INC_LO, INC_HI: begin
                ArfRegSel = 3'b100;
            end
            DONE: begin
                IRValid = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign IR = ir_q;

`ifdef FETCH_TIMEOUT_EN
    assign Fault = fault_q;
`else
    assign Fault = 1'b0;
`endif

endmodule
